// File: rtl/mux_rr_n.sv
// N-channel word mux with a registered output stage and valid/ready on every
// channel; round-robin arbitration (MODE=0) or explicit select (MODE=1).
// Ports:
//   clk_i/rst_n_i     clock and synchronous active-low reset
//   data_i/valid_i    packed channel words and per-channel valid
//   ready_o           one-hot per-channel accept
//   sel_i             channel select, used only when MODE=1
//   out_o/chan_o      registered word and the channel it came from
//   valid_o/ready_i   output handshake toward the consumer
module mux_rr_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [CHANNELS-1:0]       valid_i,
  output logic [CHANNELS-1:0]       ready_o,
  input  logic [SELW-1:0]           sel_i,
  output logic [WIDTH-1:0]          out_o,
  output logic [SELW-1:0]           chan_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int NPAD = 1 << SELW;
  localparam logic [SELW:0]   LP_CH   = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LP_LAST = SELW'(CHANNELS-1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_out;
  logic [SELW-1:0]   r_chan;
  logic [SELW-1:0]   r_ptr;

  logic [NPAD-1:0]   w_vpad;
  logic [SELW:0]     w_idx;
  logic [SELW-1:0]   w_gnt;
  logic              w_gnt_ok;
  logic              w_ld;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_data;

  // Padding to a power of two lets any index value address valid bits
  // safely; unused channels read as never valid.
  assign w_vpad = NPAD'(valid_i);

  always_comb begin
    w_gnt_ok = 1'b0;
    w_gnt    = '0;
    w_idx    = '0;
    if (MODE == 0) begin
      // Walk from farthest to nearest so the nearest requester wins.
      for (int i = CHANNELS-1; i >= 0; i--) begin
        w_idx = {1'b0, r_ptr} + (SELW+1)'(i);
        if (w_idx >= LP_CH) w_idx = w_idx - LP_CH;
        if (w_vpad[w_idx[SELW-1:0]]) begin
          w_gnt_ok = 1'b1;
          w_gnt    = w_idx[SELW-1:0];
        end
      end
    end else begin
      if (({1'b0, sel_i} < LP_CH) && w_vpad[sel_i]) begin
        w_gnt_ok = 1'b1;
        w_gnt    = sel_i;
      end
    end
  end

  assign w_ld   = (r_state == ST_EMPTY) || ready_i;
  assign w_xfer = rst_n_i && w_ld && w_gnt_ok;

  always_comb begin
    ready_o = '0;
    w_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_gnt == SELW'(k)) begin
        ready_o[k] = w_xfer;
        w_data     = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (!w_xfer && ready_i) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_out  <= w_data;
        r_chan <= w_gnt;
        if (MODE == 0) begin
          r_ptr <= (w_gnt == LP_LAST) ? '0 : w_gnt + SELW'(1);
        end
      end
    end
  end

  assign out_o   = r_out;
  assign chan_o  = r_chan;
  assign valid_o = (r_state == ST_FULL);

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: round-robin, select mode, three-channel
// wrap, backpressure and reset behaviour.
module tb_mux_rr_n;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // u0: MODE=0, 4 channels
  logic [63:0] d0;
  logic [3:0]  v0, r0;
  logic [1:0]  s0, c0;
  logic [15:0] o0;
  logic        vo0, ri0;
  // u1: MODE=1, 4 channels
  logic [63:0] d1;
  logic [3:0]  v1, r1;
  logic [1:0]  s1, c1;
  logic [15:0] o1;
  logic        vo1, ri1;
  // u2: MODE=1, 3 channels
  logic [47:0] d2;
  logic [2:0]  v2, r2;
  logic [1:0]  s2, c2;
  logic [15:0] o2;
  logic        vo2, ri2;
  // u3: MODE=0, 3 channels
  logic [47:0] d3;
  logic [2:0]  v3, r3;
  logic [1:0]  s3, c3;
  logic [15:0] o3;
  logic        vo3, ri3;

  mux_rr_n #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d0), .valid_i(v0),
    .ready_o(r0), .sel_i(s0), .out_o(o0), .chan_o(c0),
    .valid_o(vo0), .ready_i(ri0));
  mux_rr_n #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d1), .valid_i(v1),
    .ready_o(r1), .sel_i(s1), .out_o(o1), .chan_o(c1),
    .valid_o(vo1), .ready_i(ri1));
  mux_rr_n #(.WIDTH(16), .CHANNELS(3), .MODE(1)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d2), .valid_i(v2),
    .ready_o(r2), .sel_i(s2), .out_o(o2), .chan_o(c2),
    .valid_o(vo2), .ready_i(ri2));
  mux_rr_n #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d3), .valid_i(v3),
    .ready_o(r3), .sel_i(s3), .out_o(o3), .chan_o(c3),
    .valid_o(vo3), .ready_i(ri3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 4'hF; v1 = 4'hF; v2 = 3'h7; v3 = 3'h7;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++;
      if (r0 !== 4'h0 || r1 !== 4'h0 || r2 !== 3'h0 || r3 !== 3'h0) begin
        miscompares++;
        $display("FAIL rst_ready got %h %h %h %h want 0", r0, r1, r2, r3);
      end
      vecs++;
      if (o0 !== 16'h0 || c0 !== 2'd0 || vo0 !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_out got o=%h c=%0d v=%b want 0", o0, c0, vo0);
      end
    end
    rst_n = 1'b1;
    v0 = 4'h0; v1 = 4'h0; v2 = 3'h0; v3 = 3'h0;
    #1;
    vecs++;
    if (r0 !== 4'h0) begin
      miscompares++;
      $display("FAIL idle_ready got %h want 0", r0);
    end
    step();
    vecs++;
    if (o0 !== 16'h0 || c0 !== 2'd0 || vo0 !== 1'b0 || vo1 !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_out got o=%h c=%0d v=%b want 0", o0, c0, vo0);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_w [4];
    exp_w = '{16'h000A, 16'h00B0, 16'h0C00, 16'hD000};
    d0 = {16'hD000, 16'h0C00, 16'h00B0, 16'h000A};
    v0 = 4'hF;
    ri0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++;
      if (r0 !== (4'h1 << (i % 4))) begin
        miscompares++;
        $display("FAIL rr_ready[%0d] got %b want %b", i, r0, 4'h1 << (i % 4));
      end
      step();
      vecs++;
      if (o0 !== exp_w[i%4] || c0 !== 2'(i % 4) || vo0 !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_out[%0d] got o=%h c=%0d v=%b want %h %0d 1",
                 i, o0, c0, vo0, exp_w[i%4], i % 4);
      end
    end
    v0 = 4'h0;
    step();
    vecs++;
    if (vo0 !== 1'b0 || o0 !== 16'h000A || c0 !== 2'd0) begin
      miscompares++;
      $display("FAIL rr_drain got o=%h c=%0d v=%b want 000a 0 0", o0, c0, vo0);
    end
  endtask

  task automatic test_sparse_wrap();
    v0 = 4'b0100;
    #1;
    vecs++;
    if (r0 !== 4'b0100) begin
      miscompares++;
      $display("FAIL sp_ready0 got %b want 0100", r0);
    end
    step();
    vecs++;
    if (u0.r_ptr !== 2'd3) begin
      miscompares++;
      $display("FAIL sp_ptr3 got %0d want 3", u0.r_ptr);
    end
    v0 = 4'b1010;
    #1;
    vecs++;
    if (r0 !== 4'b1000) begin
      miscompares++;
      $display("FAIL sp_ready1 got %b want 1000", r0);
    end
    step();
    vecs++;
    if (c0 !== 2'd3 || o0 !== 16'hD000 || u0.r_ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL sp_g3 got c=%0d o=%h p=%0d want 3 d000 0", c0, o0, u0.r_ptr);
    end
    vecs++;
    if (r0 !== 4'b0010) begin
      miscompares++;
      $display("FAIL sp_ready2 got %b want 0010", r0);
    end
    step();
    vecs++;
    if (c0 !== 2'd1 || o0 !== 16'h00B0 || u0.r_ptr !== 2'd2) begin
      miscompares++;
      $display("FAIL sp_g1 got c=%0d o=%h p=%0d want 1 00b0 2", c0, o0, u0.r_ptr);
    end
    v0 = 4'h0;
    step();
  endtask

  task automatic test_backpressure();
    d0[32 +: 16] = 16'h1234;
    v0 = 4'hF;
    #1;
    vecs++;
    if (r0 !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_ready0 got %b want 0100", r0);
    end
    step();
    ri0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++;
      if (r0 !== 4'h0) begin
        miscompares++;
        $display("FAIL bp_ready[%0d] got %b want 0", i, r0);
      end
      step();
      vecs++;
      if (o0 !== 16'h1234 || c0 !== 2'd2 || vo0 !== 1'b1 || u0.r_ptr !== 2'd3) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got o=%h c=%0d v=%b p=%0d want 1234 2 1 3",
                 i, o0, c0, vo0, u0.r_ptr);
      end
    end
    ri0 = 1'b1;
    #1;
    vecs++;
    if (r0 !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_resume got %b want 1000", r0);
    end
    step();
    vecs++;
    if (c0 !== 2'd3 || o0 !== 16'hD000 || vo0 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_next got c=%0d o=%h v=%b want 3 d000 1", c0, o0, vo0);
    end
    v0 = 4'h0;
    step();
  endtask

  task automatic test_select();
    d1 = {16'h4444, 16'h3333, 16'hAAAA, 16'h1111};
    s1 = 2'd1;
    v1 = 4'b0010;
    ri1 = 1'b1;
    #1;
    vecs++;
    if (r1 !== 4'b0010) begin
      miscompares++;
      $display("FAIL sel_ready got %b want 0010", r1);
    end
    step();
    vecs++;
    if (o1 !== 16'hAAAA || c1 !== 2'd1 || vo1 !== 1'b1 || u1.r_ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL sel_out got o=%h c=%0d v=%b p=%0d want aaaa 1 1 0",
               o1, c1, vo1, u1.r_ptr);
    end
    s1 = 2'd3;
    v1 = 4'b0111;
    #1;
    vecs++;
    if (r1 !== 4'h0) begin
      miscompares++;
      $display("FAIL sel_nogrant got %b want 0", r1);
    end
    step();
    vecs++;
    if (vo1 !== 1'b0 || o1 !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL sel_drain got o=%h v=%b want aaaa 0", o1, vo1);
    end
    d2 = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    s2 = 2'd3;
    v2 = 3'b111;
    ri2 = 1'b1;
    #1;
    vecs++;
    if (r2 !== 3'b000) begin
      miscompares++;
      $display("FAIL sel3_oor_ready got %b want 000", r2);
    end
    step();
    vecs++;
    if (vo2 !== 1'b0 || o2 !== 16'h0) begin
      miscompares++;
      $display("FAIL sel3_oor_out got o=%h v=%b want 0 0", o2, vo2);
    end
    s2 = 2'd2;
    #1;
    vecs++;
    if (r2 !== 3'b100) begin
      miscompares++;
      $display("FAIL sel3_ready got %b want 100", r2);
    end
    step();
    vecs++;
    if (o2 !== 16'h0C0C || c2 !== 2'd2 || vo2 !== 1'b1) begin
      miscompares++;
      $display("FAIL sel3_out got o=%h c=%0d v=%b want 0c0c 2 1", o2, c2, vo2);
    end
  endtask

  task automatic test_wrap3();
    d3 = {16'h0033, 16'h0022, 16'h0011};
    v3 = 3'b111;
    ri3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (c3 !== 2'(i % 3) || vo3 !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap3[%0d] got c=%0d v=%b want %0d 1", i, c3, vo3, i % 3);
      end
    end
    vecs++;
    if (u3.r_ptr !== 2'd1) begin
      miscompares++;
      $display("FAIL wrap3_ptr got %0d want 1", u3.r_ptr);
    end
    v3 = 3'b000;
  endtask

  task automatic test_reset_mid();
    d0[16 +: 16] = 16'hBEEF;
    v0 = 4'b0010;
    ri0 = 1'b1;
    step();
    ri0 = 1'b0;
    v0 = 4'hF;
    #1;
    vecs++;
    if (o0 !== 16'hBEEF || vo0 !== 1'b1 || u0.r_ptr !== 2'd2) begin
      miscompares++;
      $display("FAIL rm_load got o=%h v=%b p=%0d want beef 1 2", o0, vo0, u0.r_ptr);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (r0 !== 4'h0) begin
      miscompares++;
      $display("FAIL rm_ready got %b want 0", r0);
    end
    step();
    vecs++;
    if (vo0 !== 1'b0 || o0 !== 16'h0 || c0 !== 2'd0 || u0.r_ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL rm_clear got o=%h c=%0d v=%b p=%0d want 0 0 0 0",
               o0, c0, vo0, u0.r_ptr);
    end
    rst_n = 1'b1;
    ri0 = 1'b1;
    #1;
    vecs++;
    if (r0 !== 4'b0001) begin
      miscompares++;
      $display("FAIL rm_scan got %b want 0001", r0);
    end
    step();
    vecs++;
    if (c0 !== 2'd0 || o0 !== 16'h000A || vo0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_first got c=%0d o=%h v=%b want 0 000a 1", c0, o0, vo0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    s0 = '0; s1 = '0; s2 = '0; s3 = '0;
    ri0 = 1'b1; ri1 = 1'b1; ri2 = 1'b1; ri3 = 1'b1;
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_backpressure();
    test_select();
    test_wrap3();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised successor to the 16-bit 2:1 mux: N-channel, WIDTH-bit selector with a registered output and a valid/ready handshake on every channel.
- Two modes: round-robin arbitration among requesting channels, or explicit select.
- Sits between multiple word producers (e.g. register/ALU result sources) and a single consumer in the datapath.
- Provides one-cycle latency, full throughput and fair arbitration.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- CHANNELS, 4, number of input channels (2..16).
- MODE, 0, 0 = round-robin arbitration, 1 = explicit select via sel_i.
- SELW, $clog2(CHANNELS), width of channel index (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- data_i  input  CHANNELS*WIDTH  packed channel words; channel k occupies bits [k*WIDTH +: WIDTH].
- valid_i  input  CHANNELS  per-channel word-valid.
- ready_o  output  CHANNELS  per-channel accept; at most one bit high per cycle.
- sel_i  input  SELW  channel select; used only when MODE=1.
- out_o  output  WIDTH  registered output word.
- chan_o  output  SELW  index of the channel that supplied out_o.
- valid_o  output  1  out_o/chan_o hold a word.
- ready_i  input  1  consumer accepts the word.

Behaviour:
- Reset: on a clk_i edge with rst_n_i=0, set out_o=0, chan_o=0, valid_o=0 and rr pointer ptr=0. Any held word is discarded (reset mid-operation drops it). ready_o is all zero while rst_n_i=0.
- Output stage is a single register with two states:
  - EMPTY: valid_o=0.
  - FULL: valid_o=1.
- Load enable: ld = !valid_o || ready_i. ld is combinational, which allows a drain and a refill in the same cycle for full throughput.
- Grant g (combinational):
  - MODE=0: g is the first k with valid_i[k]=1, scanning ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1. There is no grant if valid_i is all zero.
  - MODE=1: g = sel_i when sel_i < CHANNELS and valid_i[sel_i]=1. Otherwise there is no grant; out-of-range sel_i never grants and never produces X.
- ready_o[k] = rst_n_i && ld && grant_exists && (g==k). ready_o never depends on ready_o itself; it may depend combinationally on valid_i, sel_i and ready_i.
- Channel transfer when valid_i[g] && ready_o[g]. On that edge:
  - out_o <= data_i[g*WIDTH +: WIDTH]
  - chan_o <= g
  - valid_o <= 1
  - MODE=0 only: ptr <= (g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- Output transfer when valid_o && ready_i. If no channel transfer happens in the same cycle, valid_o <= 0. out_o and chan_o keep their last values when EMPTY; they are not cleared.
- State transitions:
  - EMPTY -> FULL on a channel transfer.
  - FULL -> FULL on a simultaneous output and channel transfer.
  - FULL -> EMPTY on an output transfer with no grant.
  - FULL stalls while ready_i=0. out_o and chan_o must stay stable, ready_o must stay all zero and ptr must not change.
- Latency: a word accepted at edge n appears on out_o with valid_o=1 after edge n. Throughput is one word per cycle when ready_i is held at 1.
- ptr advances only on an actual grant, never on idle cycles. In MODE=1, ptr stays 0.
- Fairness (MODE=0): with all channels continuously valid and ready_i=1, the grant sequence is 0,1,…,CHANNELS-1,0,…. No channel waits more than CHANNELS-1 grants.
- Width rules: no arithmetic on data. The pointer increment is modulo CHANNELS, including when CHANNELS is not a power of two (e.g. CHANNELS=3: 2 -> 0).

Test Plan:
- Reset/idle: hold rst_n_i=0 for 2 cycles with all valid_i=1, then release with valid_i=0 -> out_o=0, chan_o=0, valid_o=0 and ready_o=0 throughout.
- Round-robin, MODE=0, CHANNELS=4, WIDTH=16: data = 0x000A, 0x00B0, 0x0C00, 0xD000; all valid; ready_i=1 -> out_o sequence 0x000A, 0x00B0, 0x0C00, 0xD000, 0x000A; chan_o = 0,1,2,3,0; valid_o=1 from the first edge after the first grant.
- Sparse requests with wrap: ptr=3, only valid_i[1] and valid_i[3] set -> grant 3 then 1; ptr becomes 0 then 2; ready_o one-hot each cycle.
- Backpressure: FULL holding 0x1234 from channel 2; ready_i=0 for 5 cycles while all channels are valid -> out_o=0x1234 and chan_o=2 stable, ready_o=0, ptr unchanged. When ready_i rises, the next word comes from channel 3 on the following edge.
- Explicit select, MODE=1: with sel_i=1, valid_i=4'b0010 and data channel 1 = 0xAAAA, out_o=0xAAAA. With sel_i=3 while valid_i[3]=0, there is no grant and valid_o drops after drain. With CHANNELS=3, sel_i=3 never grants and never produces X.
- Reset mid-operation: valid_o=1 with out_o=0xBEEF and ready_i=0; assert rst_n_i for 1 cycle -> valid_o=0, out_o=0, ptr=0. The next grant scans from channel 0.
